keypad_scan: RTL and testbench

//  Input-side counterpart of the multiplexed 7-seg display driver: time-multiplexed scanner for a
//  4x4 matrix keypad. Drives one row low at a time, samples the active-low columns, debounces

---
 rtl/keypad_scan_if.sv | 25 ++
 rtl/keypad_scan.sv | 185 ++++++++++++++++++
 tb/tb_keypad_scan.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_if.sv
// Keypad-side and key-event signals of the matrix keypad scanner.
// The scanner drives rows and events; the keypad and consumer logic sit on the slave side.
interface keypad_scan_if;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    modport master (
        input  col_n,
        output row_n,
        output key_code,
        output key_valid,
        output key_down
    );

    modport slave (
        output col_n,
        input  row_n,
        input  key_code,
        input  key_valid,
        input  key_down
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives one row low at a time, samples synchronized columns,
// debounces over whole scans and reports one key event per accepted press.
module keypad_scan #(
    parameter int unsigned ROW_TICKS = 50000,
    parameter int unsigned DEB_SCANS = 4
) (
    input  logic          clk,
    input  logic          reset,
    keypad_scan_if.master kp
);

    localparam int unsigned TICK_W = $clog2(ROW_TICKS);
    localparam int unsigned CNT_W  = $clog2(DEB_SCANS + 1);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(ROW_TICKS - 1);
    localparam logic [CNT_W-1:0]  CNT_STABLE = CNT_W'(DEB_SCANS);

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_KEY   = 2'd1,
        RES_MULTI = 2'd2
    } res_kind_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } state_e;

    logic [3:0]        sync1_q, sync1_d;
    logic [3:0]        sync2_q, sync2_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [1:0]        row_q, row_d;
    logic [3:0]        row_n_q, row_n_d;
    logic [1:0]        acc_n_q, acc_n_d;
    logic [3:0]        acc_code_q, acc_code_d;
    res_kind_e         cand_kind_q, cand_kind_d;
    logic [3:0]        cand_code_q, cand_code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    state_e            state_q, state_d;
    logic [3:0]        key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_down_q, key_down_d;

    logic              sample_c;
    logic              scan_end_c;
    logic [3:0]        lows_c;
    logic [2:0]        pop_c;
    logic [1:0]        col_idx_c;
    logic [2:0]        sum_c;
    logic [1:0]        new_n_c;
    logic [3:0]        new_code_c;
    res_kind_e         res_kind_c;
    logic [3:0]        res_code_c;
    logic              stable_c;

    always_comb begin
        sync1_d     = kp.col_n;
        sync2_d     = sync1_q;
        tick_d      = tick_q;
        row_d       = row_q;
        row_n_d     = row_n_q;
        acc_n_d     = acc_n_q;
        acc_code_d  = acc_code_q;
        cand_kind_d = cand_kind_q;
        cand_code_d = cand_code_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        pop_c       = 3'd0;
        col_idx_c   = 2'd0;
        res_kind_c  = RES_NONE;
        res_code_c  = 4'd0;
        stable_c    = 1'b0;

        sample_c   = (tick_q == TICK_LAST);
        scan_end_c = sample_c && (row_q == 2'd3);

        // Count low columns in this row and remember where a lone one sits.
        lows_c = ~sync2_q;
        for (int i = 0; i < 4; i++) begin
            pop_c = pop_c + 3'(lows_c[i]);
        end
        for (int i = 3; i >= 0; i--) begin
            if (lows_c[i]) col_idx_c = 2'(i);
        end
        sum_c      = 3'(acc_n_q) + pop_c;
        new_n_c    = (sum_c >= 3'd2) ? 2'd2 : sum_c[1:0];
        new_code_c = (acc_n_q == 2'd0 && pop_c == 3'd1) ? {row_q, col_idx_c} : acc_code_q;

        if (sample_c) begin
            tick_d     = '0;
            row_d      = row_q + 2'd1;
            row_n_d    = ~(4'd1 << row_d);
            acc_n_d    = new_n_c;
            acc_code_d = new_code_c;
        end else begin
            tick_d = tick_q + TICK_W'(1);
        end

        if (scan_end_c) begin
            acc_n_d    = 2'd0;
            acc_code_d = 4'd0;
            case (new_n_c)
                2'd0:    res_kind_c = RES_NONE;
                2'd1:    res_kind_c = RES_KEY;
                default: res_kind_c = RES_MULTI;
            endcase
            res_code_c = (res_kind_c == RES_KEY) ? new_code_c : 4'd0;

            // Chords/ghosting never count toward stability.
            if (res_kind_c == RES_MULTI) begin
                cnt_d       = '0;
                cand_kind_d = RES_MULTI;
                cand_code_d = 4'd0;
            end else if (res_kind_c == cand_kind_q && res_code_c == cand_code_q) begin
                cnt_d = (cnt_q == CNT_STABLE) ? cnt_q : cnt_q + CNT_W'(1);
            end else begin
                cnt_d       = CNT_W'(1);
                cand_kind_d = res_kind_c;
                cand_code_d = res_code_c;
            end
            stable_c = (cnt_d == CNT_STABLE);

            case (state_q)
                ST_IDLE: begin
                    if (stable_c && res_kind_c == RES_KEY) begin
                        state_d     = ST_PRESSED;
                        key_code_d  = res_code_c;
                        key_down_d  = 1'b1;
                        key_valid_d = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    // A different key or a chord is ignored until a clean release.
                    if (stable_c && res_kind_c == RES_NONE) begin
                        state_d    = ST_IDLE;
                        key_down_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 4'b1111;
            sync2_q     <= 4'b1111;
            tick_q      <= '0;
            row_q       <= 2'd0;
            row_n_q     <= 4'b1110;
            acc_n_q     <= 2'd0;
            acc_code_q  <= 4'd0;
            cand_kind_q <= RES_NONE;
            cand_code_q <= 4'd0;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            tick_q      <= tick_d;
            row_q       <= row_d;
            row_n_q     <= row_n_d;
            acc_n_q     <= acc_n_d;
            acc_code_q  <= acc_code_d;
            cand_kind_q <= cand_kind_d;
            cand_code_q <= cand_code_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign kp.row_n     = row_n_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with ROW_TICKS=4, DEB_SCANS=3 (one scan = 16 clks).
// Presses are applied at scan boundaries so event latencies are exact.
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] keys;
    logic [3:0]  col_model;
    int          checks = 0;
    int          failures = 0;
    int          pulse_cnt = 0;
    int          lat;
    logic        got;
    logic        seen;
    logic [3:0]  exp_row;

    keypad_scan_if kp_if ();

    keypad_scan #(.ROW_TICKS(4), .DEB_SCANS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp_if.master)
    );

    always #5 clk = ~clk;

    // Pressed key at (r,c) pulls column c low while row r is driven.
    always_comb begin
        col_model = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !kp_if.row_n[r]) col_model[c] = 1'b0;
            end
        end
    end
    assign kp_if.col_n = col_model;

    always @(posedge clk) begin
        #1;
        if (kp_if.key_valid === 1'b1) pulse_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid();
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (kp_if.key_valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic wait_up();
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (kp_if.key_down === 1'b0) got = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1;
        keys  = 16'h0000;

        // 1: reset values and row rotation
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_row_n", 32'(kp_if.row_n), 32'h E);
        check("rst_key_code", 32'(kp_if.key_code), 32'h0);
        check("rst_key_valid", 32'(kp_if.key_valid), 32'h0);
        check("rst_key_down", 32'(kp_if.key_down), 32'h0);
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_row = ~(4'd1 << (k / 4));
            check("row_cycle", 32'(kp_if.row_n), 32'(exp_row));
            @(negedge clk);
        end

        // 2: press r2,c1 at a scan boundary
        keys[9] = 1'b1;
        wait_valid();
        check("t2_valid", 32'(got), 32'h1);
        check("t2_latency", 32'(lat), 32'd48);
        check("t2_code", 32'(kp_if.key_code), 32'h9);
        check("t2_down", 32'(kp_if.key_down), 32'h1);
        @(negedge clk);
        check("t2_one_cycle", 32'(kp_if.key_valid), 32'h0);
        repeat (319) @(negedge clk);
        check("t2_no_retrigger", 32'(pulse_cnt), 32'd1);
        check("t2_still_down", 32'(kp_if.key_down), 32'h1);

        // 3: release r2,c1
        keys[9] = 1'b0;
        wait_up();
        check("t3_release", 32'(got), 32'h1);
        check("t3_latency", 32'(lat), 32'd48);
        check("t3_code_held", 32'(kp_if.key_code), 32'h9);
        check("t3_no_pulse", 32'(pulse_cnt), 32'd1);

        // 4: r1,c3 bouncing every scan never settles
        seen = 1'b0;
        for (int s = 0; s < 20; s++) begin
            keys[7] = (s % 2 == 0);
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                if (kp_if.key_down !== 1'b0) seen = 1'b1;
            end
        end
        keys[7] = 1'b0;
        repeat (64) @(negedge clk);
        check("t4_no_pulse", 32'(pulse_cnt), 32'd1);
        check("t4_never_down", 32'(seen), 32'h0);

        // 5: chord r0,c0 + r3,c3, then release r3,c3
        keys[0]  = 1'b1;
        keys[15] = 1'b1;
        repeat (160) @(negedge clk);
        check("t5_chord_no_pulse", 32'(pulse_cnt), 32'd1);
        check("t5_chord_up", 32'(kp_if.key_down), 32'h0);
        keys[15] = 1'b0;
        wait_valid();
        check("t5_valid", 32'(got), 32'h1);
        check("t5_latency", 32'(lat), 32'd48);
        check("t5_code", 32'(kp_if.key_code), 32'h0);
        check("t5_down", 32'(kp_if.key_down), 32'h1);
        check("t5_pulses", 32'(pulse_cnt), 32'd2);
        keys[0] = 1'b0;
        wait_up();
        check("t5_release_lat", 32'(lat), 32'd48);

        // 6: reset mid-debounce discards partial history
        keys[14] = 1'b1;
        repeat (32) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_rst_row_n", 32'(kp_if.row_n), 32'hE);
        check("t6_rst_down", 32'(kp_if.key_down), 32'h0);
        check("t6_rst_valid", 32'(kp_if.key_valid), 32'h0);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 48; i++) begin
            if (kp_if.key_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        check("t6_no_early_pulse", 32'(seen), 32'h0);
        check("t6_valid", 32'(kp_if.key_valid), 32'h1);
        check("t6_code", 32'(kp_if.key_code), 32'hE);
        check("t6_down", 32'(kp_if.key_down), 32'h1);
        @(negedge clk);
        check("t6_one_cycle", 32'(kp_if.key_valid), 32'h0);
        check("t6_pulses", 32'(pulse_cnt), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
